// File: rtl/if_id_stage_buffer.sv
// IF/ID pipeline register: pairs an opcode word with an optional immediate word
// and presents one registered packet (instruction, immediate, PC, valid) to decode.
//
// state | meaning
// ------+----------------------------------------------------------
// S_OP  | next fetched word is an opcode
// S_IMM | opcode with immediate flag is held, next word is its immediate
module if_id_stage_buffer #(
  parameter int          IMM_FLAG_BIT = 0,
  parameter logic [15:0] NOP_WORD     = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] instr_in,
  input  logic [31:0] pc_in,
  output logic [15:0] instr_out,
  output logic [15:0] imm_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  output logic        imm_pending
);

  typedef enum logic {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } state_t;

  state_t      state_q, state_d;

  logic [15:0] hold_op_q, hold_op_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] imm_q, imm_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  logic        advance;
  logic        imm_flag;

  // flush outranks stall, so a flushed cycle never advances the pipeline
  assign advance  = !flush && !stall;
  assign imm_flag = instr_in[IMM_FLAG_BIT];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_OP;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_OP;
    end else if (advance) begin
      case (state_q)
        S_OP:    state_d = imm_flag ? S_IMM : S_OP;
        S_IMM:   state_d = S_OP;
        default: state_d = S_OP;
      endcase
    end
  end

  always_comb begin
    hold_op_d = hold_op_q;
    hold_pc_d = hold_pc_q;
    instr_d   = instr_q;
    imm_d     = imm_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    if (flush) begin
      instr_d = NOP_WORD;
      imm_d   = 16'h0000;
      valid_d = 1'b0;
    end else if (advance) begin
      case (state_q)
        S_OP: begin
          if (imm_flag) begin
            hold_op_d = instr_in;
            hold_pc_d = pc_in;
            instr_d   = NOP_WORD;
            imm_d     = 16'h0000;
            valid_d   = 1'b0;
          end else begin
            instr_d = instr_in;
            imm_d   = 16'h0000;
            pc_d    = pc_in;
            valid_d = 1'b1;
          end
        end
        S_IMM: begin
          // the immediate word is taken verbatim, its flag bit is not examined
          instr_d = hold_op_q;
          imm_d   = instr_in;
          pc_d    = hold_pc_q;
          valid_d = 1'b1;
        end
        default: begin
          instr_d = NOP_WORD;
          imm_d   = 16'h0000;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_op_q <= 16'h0000;
      hold_pc_q <= 32'h0000_0000;
      instr_q   <= NOP_WORD;
      imm_q     <= 16'h0000;
      pc_q      <= 32'h0000_0000;
      valid_q   <= 1'b0;
    end else begin
      hold_op_q <= hold_op_d;
      hold_pc_q <= hold_pc_d;
      instr_q   <= instr_d;
      imm_q     <= imm_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
    end
  end

  assign instr_out   = instr_q;
  assign imm_out     = imm_q;
  assign pc_out      = pc_q;
  assign valid_out   = valid_q;
  assign imm_pending = (state_q == S_IMM);

endmodule
